// File: rtl/port_b_arbiter_pkg.sv
// Shared types for the port B arbiter: ownership state encoding and requester IDs.
package port_b_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_ENG  = 2'd2
    } arb_state_e;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_ENG  = 1'b1;

    function automatic arb_state_e owner_state(input logic id);
        return (id == REQ_ENG) ? ST_ENG : ST_HOST;
    endfunction

endpackage

// File: rtl/port_b_rd_tracker.sv
// Remembers which requester issued last cycle's read and routes mem_q back to it.
module port_b_rd_tracker
    import port_b_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_fire_i,
    input  logic                  rd_tag_i,
    input  logic [DATA_WIDTH-1:0] mem_q_i,
    output logic                  h_rvalid_o,
    output logic [DATA_WIDTH-1:0] h_rdata_o,
    output logic                  e_rvalid_o,
    output logic [DATA_WIDTH-1:0] e_rdata_o
);

    logic valid_q, valid_d;
    logic tag_q, tag_d;

    // next tag/valid: capture every granted read, otherwise go empty
    always_comb begin
        valid_d = 1'b0;
        tag_d   = tag_q;
        if (rd_fire_i) begin
            valid_d = 1'b1;
            tag_d   = rd_tag_i;
        end else begin
            valid_d = 1'b0;
            tag_d   = tag_q;
        end
    end

    // tag/valid register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            tag_q   <= REQ_HOST;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    // mem_q is only valid one cycle after its address, so the demux is combinational
    always_comb begin
        h_rvalid_o = 1'b0;
        e_rvalid_o = 1'b0;
        h_rdata_o  = {DATA_WIDTH{1'b0}};
        e_rdata_o  = {DATA_WIDTH{1'b0}};
        if (valid_q && (tag_q == REQ_ENG)) begin
            e_rvalid_o = 1'b1;
            e_rdata_o  = mem_q_i;
        end else if (valid_q) begin
            h_rvalid_o = 1'b1;
            h_rdata_o  = mem_q_i;
        end else begin
            h_rvalid_o = 1'b0;
            e_rvalid_o = 1'b0;
        end
    end

endmodule

// File: rtl/port_b_arbiter.sv
// Memory port B arbiter: host vs. engine, same-cycle grant, bounded-burst
// round-robin, engine lock and read-return routing.
module port_b_arbiter
    import port_b_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_BURST  = 8,
    parameter int BURST_LOG  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_wdata,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [DATA_WIDTH-1:0] e_rdata,
    input  logic                  e_lock,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [BURST_LOG-1:0] MAX_CNT = BURST_LOG'(MAX_BURST);
    localparam logic [BURST_LOG-1:0] ONE_CNT = BURST_LOG'(1);

    arb_state_e           state_q, state_d;
    logic                 last_owner_q, last_owner_d;
    logic [BURST_LOG-1:0] burst_cnt_q, burst_cnt_d;

    logic h_gnt_s, e_gnt_s, any_gnt_s, win_id_s, burst_open_s, win_we_s;

    assign burst_open_s = (burst_cnt_q < MAX_CNT);
    assign any_gnt_s    = h_gnt_s | e_gnt_s;
    assign win_id_s     = e_gnt_s ? REQ_ENG : REQ_HOST;
    assign win_we_s     = e_gnt_s ? e_we : h_we;

    // grant decision; on a tie the current owner keeps the port until its burst is spent
    always_comb begin
        h_gnt_s = 1'b0;
        e_gnt_s = 1'b0;
        if (e_lock) begin
            e_gnt_s = e_req;
        end else if (h_req && e_req) begin
            if ((state_q == ST_HOST) && burst_open_s) begin
                h_gnt_s = 1'b1;
            end else if ((state_q == ST_ENG) && burst_open_s) begin
                e_gnt_s = 1'b1;
            end else if (last_owner_q == REQ_HOST) begin
                e_gnt_s = 1'b1;
            end else begin
                h_gnt_s = 1'b1;
            end
        end else begin
            h_gnt_s = h_req;
            e_gnt_s = e_req;
        end
    end

    // next ownership state and saturating burst count
    always_comb begin
        state_d      = ST_IDLE;
        last_owner_d = last_owner_q;
        burst_cnt_d  = {BURST_LOG{1'b0}};
        if (any_gnt_s) begin
            state_d      = owner_state(win_id_s);
            last_owner_d = win_id_s;
            if (state_q == owner_state(win_id_s)) begin
                burst_cnt_d = burst_open_s ? (burst_cnt_q + ONE_CNT) : MAX_CNT;
            end else begin
                burst_cnt_d = ONE_CNT;
            end
        end else begin
            state_d     = ST_IDLE;
            burst_cnt_d = {BURST_LOG{1'b0}};
        end
    end

    // arbitration state register; reset leaves host as last owner so engine wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= REQ_HOST;
            burst_cnt_q  <= {BURST_LOG{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // port B bus mux, zeroed when nobody is granted
    always_comb begin
        mem_addr = {ADDR_WIDTH{1'b0}};
        mem_data = {DATA_WIDTH{1'b0}};
        mem_we   = 1'b0;
        if (e_gnt_s) begin
            mem_addr = e_addr;
            mem_data = e_wdata;
            mem_we   = e_we;
        end else if (h_gnt_s) begin
            mem_addr = h_addr;
            mem_data = h_wdata;
            mem_we   = h_we;
        end else begin
            mem_we   = 1'b0;
        end
    end

    assign h_gnt = h_gnt_s;
    assign e_gnt = e_gnt_s;

    port_b_rd_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_tracker (
        .clk        (clk),
        .reset      (reset),
        .rd_fire_i  (any_gnt_s & ~win_we_s),
        .rd_tag_i   (win_id_s),
        .mem_q_i    (mem_q),
        .h_rvalid_o (h_rvalid),
        .h_rdata_o  (h_rdata),
        .e_rvalid_o (e_rvalid),
        .e_rdata_o  (e_rdata)
    );

endmodule

// File: tb/tb_port_b_arbiter.sv
// Scoreboard bench for port_b_arbiter: directed scenarios plus random traffic
// against a cycle-level grant model and a shadow memory.
module tb_port_b_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MB = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          h_req, h_we, e_req, e_we, e_lock;
    logic [AW-1:0] h_addr, e_addr;
    logic [DW-1:0] h_wdata, e_wdata;
    logic          h_gnt, h_rvalid, e_gnt, e_rvalid;
    logic [DW-1:0] h_rdata, e_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_we;

    port_b_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .BURST_LOG(BL)) dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .e_lock(e_lock),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // synchronous single-port memory behind port B
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    typedef struct { int stamp; logic [DW-1:0] data; } rd_exp_t;
    rd_exp_t hq[$];
    rd_exp_t eq[$];

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    // model of ownership: 0 none, 1 host, 2 engine
    int prev_own, run_len, last_win;
    int h_cnt = 0, e_cnt = 0;
    bit h_pend, e_pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one cycle: predict the winner from the arbitration rules, compare, update model
    task automatic tick();
        int win;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic ew;
        rd_exp_t x;
        @(negedge clk);
        win = 0;
        if (e_lock) win = e_req ? 2 : 0;
        else if (h_req && e_req) begin
            if (prev_own != 0 && run_len < MB) win = prev_own;
            else win = (last_win == 1) ? 2 : 1;
        end
        else if (h_req) win = 1;
        else if (e_req) win = 2;
        check("h_gnt", h_gnt, 64'(win == 1));
        check("e_gnt", e_gnt, 64'(win == 2));
        ea = '0; ed = '0; ew = 1'b0;
        if (win == 1) begin ea = h_addr; ed = h_wdata; ew = h_we; end
        else if (win == 2) begin ea = e_addr; ed = e_wdata; ew = e_we; end
        check("mem_addr", mem_addr, ea);
        check("mem_data", mem_data, ed);
        check("mem_we", mem_we, ew);
        if (win != 0) begin
            if (ew) ref_mem[ea] = ed;
            else begin
                x.stamp = cyc + 1;
                x.data = ref_mem[ea];
                if (win == 1) hq.push_back(x); else eq.push_back(x);
            end
            run_len = (win == prev_own) ? ((run_len < MB) ? run_len + 1 : MB) : 1;
            prev_own = win;
            last_win = win;
            if (win == 1) begin h_cnt++; h_pend = 0; end
            else begin e_cnt++; e_pend = 0; end
        end else begin
            prev_own = 0;
            run_len = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // read-return monitor: pops the scoreboard whenever a read is due this cycle
    always @(negedge clk) begin
        if (reset) begin
            if (hq.size() > 0 && hq[0].stamp == cyc) begin
                check("h_rvalid", h_rvalid, 1);
                check("h_rdata", h_rdata, hq[0].data);
                void'(hq.pop_front());
            end else begin
                check("h_rvalid_idle", h_rvalid, 0);
                check("h_rdata_idle", h_rdata, 0);
            end
            if (eq.size() > 0 && eq[0].stamp == cyc) begin
                check("e_rvalid", e_rvalid, 1);
                check("e_rdata", e_rdata, eq[0].data);
                void'(eq.pop_front());
            end else begin
                check("e_rvalid_idle", e_rvalid, 0);
                check("e_rdata_idle", e_rdata, 0);
            end
        end
    end

    task automatic model_reset();
        prev_own = 0; run_len = 0; last_win = 1;
        hq.delete(); eq.delete();
    endtask

    task automatic set_h(input logic r, input logic w, input int a, input logic [DW-1:0] d);
        h_req = r; h_we = w; h_addr = AW'(a); h_wdata = d;
    endtask

    task automatic set_e(input logic r, input logic w, input int a, input logic [DW-1:0] d);
        e_req = r; e_we = w; e_addr = AW'(a); e_wdata = d;
    endtask

    task automatic gen_random();
        if (!h_pend) begin
            if ($urandom_range(3) != 0) begin
                h_pend = 1;
                set_h(1'b1, 1'($urandom_range(1)), $urandom_range(15), $urandom);
            end else h_req = 1'b0;
        end else if ($urandom_range(15) == 0) begin
            h_pend = 0; h_req = 1'b0;
        end
        if (!e_pend) begin
            if ($urandom_range(3) != 0) begin
                e_pend = 1;
                set_e(1'b1, 1'($urandom_range(1)), $urandom_range(15), $urandom);
            end else e_req = 1'b0;
        end else if ($urandom_range(15) == 0) begin
            e_pend = 0; e_req = 1'b0;
        end
        if ($urandom_range(19) == 0) e_lock = ~e_lock;
    endtask

    initial begin
        int h0, e0;
        bit seen;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'(i) ^ 32'h5A5A_0000;
            ref_mem[i] = 32'(i) ^ 32'h5A5A_0000;
        end
        reset = 1'b0; e_lock = 1'b0;
        set_h(1'b0, 1'b0, 0, '0);
        set_e(1'b0, 1'b0, 0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_h_gnt", h_gnt, 0);
        check("rst_e_gnt", e_gnt, 0);
        check("rst_h_rvalid", h_rvalid, 0);
        check("rst_e_rvalid", e_rvalid, 0);
        check("rst_mem_we", mem_we, 0);
        reset = 1'b1;

        // idle after reset
        repeat (10) tick();

        // host write then read of addr 5
        set_h(1'b1, 1'b1, 5, 32'h0000_DEAD);
        tick();
        set_h(1'b1, 1'b0, 5, 32'h0);
        tick();
        set_h(1'b0, 1'b0, 0, '0);
        check("wr_rd_hgnt_count", h_cnt, 2);
        tick();
        check("ref_addr5", ref_mem[5], 32'h0000_DEAD);
        tick();

        // both reading continuously: runs of MB starting with the engine
        h0 = h_cnt; e0 = e_cnt;
        set_h(1'b1, 1'b0, 1, '0);
        set_e(1'b1, 1'b0, 2, '0);
        tick();
        check("tie_first_eng", e_cnt - e0, 1);
        repeat (39) tick();
        check("burst_eng_total", e_cnt - e0, 24);
        check("burst_host_total", h_cnt - h0, 16);

        // engine lock for 20 cycles
        h0 = h_cnt; e0 = e_cnt;
        e_lock = 1'b1;
        repeat (20) tick();
        check("lock_eng_grants", e_cnt - e0, 20);
        check("lock_host_grants", h_cnt - h0, 0);
        e_lock = 1'b0;
        seen = 0;
        for (int i = 0; i < MB && !seen; i++) begin
            tick();
            if (h_cnt != h0) seen = 1;
        end
        check("unlock_host_in_burst", seen, 1);

        // engine writes addr 3, then reads it while host withdraws
        set_e(1'b1, 1'b1, 3, 32'h0000_0011);
        set_h(1'b1, 1'b0, 7, '0);
        e_lock = 1'b1;
        tick();
        e_lock = 1'b0;
        set_h(1'b0, 1'b0, 0, '0);
        set_e(1'b1, 1'b0, 3, '0);
        tick();
        set_e(1'b0, 1'b0, 0, '0);
        tick();
        tick();

        // reset in the cycle after a granted read
        set_h(1'b1, 1'b0, 5, '0);
        tick();
        set_h(1'b0, 1'b0, 0, '0);
        reset = 1'b0;
        #1;
        check("rst_mid_h_rvalid", h_rvalid, 0);
        check("rst_mid_h_rdata", h_rdata, 0);
        check("rst_mid_e_rvalid", e_rvalid, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        e0 = e_cnt;
        set_h(1'b1, 1'b0, 9, '0);
        set_e(1'b1, 1'b0, 10, '0);
        tick();
        check("post_rst_tie_eng", e_cnt - e0, 1);

        // random traffic
        set_h(1'b0, 1'b0, 0, '0);
        set_e(1'b0, 1'b0, 0, '0);
        h_pend = 0; e_pend = 0;
        for (int i = 0; i < 800; i++) begin
            gen_random();
            tick();
        end
        set_h(1'b0, 1'b0, 0, '0);
        set_e(1'b0, 1'b0, 0, '0);
        e_lock = 1'b0;
        repeat (3) tick();
        check("h_queue_drained", hq.size(), 0);
        check("e_queue_drained", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/port_b_arbiter.md
# port_b_arbiter

Arbitrates memory port B of the dual-port matrix memory between two requesters: the host load/unload interface and the multiplier engine. Replaces the hard `is_working` mux with a per-cycle request/grant handshake, bounded-burst round-robin fairness, an engine lock and read-return routing. Sits between the host interface and engine on one side and the memory's port B on the other; port A stays engine-private.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 12, memory address width
- MAX_BURST, 8, max consecutive grants to one requester while the other is waiting
- BURST_LOG, 4, width of burst counter (must hold MAX_BURST)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- h_req  in  1  host request, held until granted
- h_we  in  1  host write (1) / read (0)
- h_addr  in  ADDR_WIDTH  host address
- h_wdata  in  DATA_WIDTH  host write data
- h_gnt  out  1  host access accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DATA_WIDTH  host read data
- e_req, e_we, e_addr, e_wdata, e_gnt, e_rvalid, e_rdata  same as host, engine side
- e_lock  in  1  engine exclusive ownership; host never granted while high
- mem_addr  out  ADDR_WIDTH  port B address
- mem_data  out  DATA_WIDTH  port B write data
- mem_we  out  1  port B write enable
- mem_q  in  DATA_WIDTH  port B read data, valid one cycle after address

## Operation
- States: IDLE (no grant last cycle), HOST, ENG (owner of last cycle's grant). Extra reg last_owner (tie-break), burst_cnt.
- Grant (combinational, same cycle): at most one gnt high.
  - e_lock high: e_gnt = e_req; h_gnt = 0.
  - Only one req: grant it.
  - Both req: if state owner X and burst_cnt < MAX_BURST grant X; else grant the requester that is not last_owner.
- On grant: mem_addr/mem_data/mem_we driven from granted requester; state = granted side; last_owner = granted side; burst_cnt = cnt+1 (saturate at MAX_BURST) if same owner, else 1.
- No grant: state IDLE, burst_cnt 0, last_owner kept; mem_we 0, mem_addr 0, mem_data 0.
- Read return: granted read registers a 1-bit tag + valid; next cycle matching rvalid = 1, rdata = mem_q. Non-matching rdata = 0.
- Writes produce no rvalid.

## Timing
- Reset values: state IDLE, last_owner = host (engine wins first tie), burst_cnt 0, h_rvalid/e_rvalid 0, h_rdata/e_rdata 0, h_gnt/e_gnt 0, mem_we 0.
- Grant latency 0 cycles (req and gnt same cycle); read latency 1 cycle gnt→rvalid; one access/cycle back-to-back sustained.
- Requester must hold req/we/addr/wdata stable until gnt; deasserting before gnt is legal (request withdrawn).
- Burst limit only enforced when the other side requests; lone requester is granted every cycle, counter saturates.
- e_lock rising during host burst: host loses grant that cycle; host read granted the previous cycle still returns rvalid.
- e_lock falling with both requesting: normal rule applies; state ENG, so engine continues until MAX_BURST, then host.
- reset asserted mid-operation: in-flight rvalid dropped immediately; requesters reissue.

## Structure
- Shared package: state encoding (IDLE/HOST/ENG), requester IDs (REQ_HOST=0, REQ_ENG=1).
- One sub-module: port_b_rd_tracker (1-cycle tag/valid register, rvalid/rdata demux).
- Top-level matrix_multiplier instantiates port_b_arbiter in place of the is_working mux; e_lock driven by engine is_working.

## Test plan
- Reset, no requests → all gnt/rvalid/mem_we 0, mem_addr 0 for 10 cycles.
- Host write addr 5 data 0xDEAD, next cycle host read addr 5 → h_gnt both cycles, h_rvalid one cycle after read gnt, h_rdata 0xDEAD, e_rvalid 0.
- Both requesters continuously reading, MAX_BURST=8 → first grant engine, then alternating runs of exactly 8 grants each, no idle cycles.
- e_lock high with host and engine requesting for 20 cycles → 20 engine grants, 0 host grants; lock low → host granted within MAX_BURST cycles.
- Engine reads addr 3 (data 0x11) while host withdraws req → e_rvalid next cycle with 0x11; h_rvalid stays 0.
- Reset asserted in cycle after a granted read → no rvalid, state IDLE, next tie goes to engine.
